// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Brief    : Instruction-memory request/response bus (req/gnt/rvalid) between
//            the fetch stage (master) and instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : IF stage. Owns the PC, issues in-order word fetches, buffers
//            returned words in a small FIFO and feeds decode. EX redirects
//            flush the buffer and discard responses still in flight.
//            Optional macro FETCH_PERF_EN adds perf_fetched,
//            perf_stall_cycles and perf_discarded counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  wire                 clk,
  input  wire                 rst_n,
  input  wire                 stall,
  input  wire                 redirect_valid,
  input  wire [31:0]          redirect_pc,
  instruction_fetch_if.master imem,
  output logic [31:0]         out_instr,
  output logic [31:0]         out_pc,
  output logic                out_noop
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_discarded
`endif
);

  localparam int          C_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int          C_CNT_W = C_PTR_W + 1;
  localparam int          C_SUM_W = C_CNT_W + 1;
  localparam logic [31:0] C_NOP   = 32'h0000_0013;

  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        deliver_pc_q, deliver_pc_d;
  logic [31:0]        fifo_q [BUF_DEPTH];
  logic [31:0]        fifo_d [BUF_DEPTH];
  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0] count_q, count_d;
  logic [C_CNT_W-1:0] inflight_q, inflight_d;
  logic [C_CNT_W-1:0] discard_q, discard_d;
  logic [31:0]        out_instr_q, out_instr_d;
  logic [31:0]        out_pc_q, out_pc_d;
  logic               out_noop_q, out_noop_d;

  logic [C_SUM_W-1:0] w_level;
  logic               w_req;
  logic               w_grant;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_pop_data;
  logic [31:0]        w_target;

  // Credit check, request qualification and response classification.
  always_comb begin
    w_level    = C_SUM_W'(inflight_q) + C_SUM_W'(count_q);
    // Reset gating keeps the bus quiet while rst_n is held low.
    w_req      = rst_n && (w_level < C_SUM_W'(BUF_DEPTH)) &&
                 !redirect_valid && (discard_q == '0);
    w_grant    = w_req && imem.imem_gnt;
    // Responses in a redirect cycle or owed to an older redirect are wrong-path.
    w_drop     = imem.imem_rvalid && (redirect_valid || (discard_q != '0));
    w_push     = imem.imem_rvalid && !w_drop;
    w_pop      = !redirect_valid && !stall && ((count_q != '0) || w_push);
    // An empty FIFO forwards the arriving word straight to the output register.
    w_pop_data = (count_q != '0) ? fifo_q[rd_ptr_q] : imem.imem_rdata;
    w_target   = redirect_pc & ~32'h0000_0003;
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = fetch_pc_q;

  // Next-state for PCs, FIFO, credit counters and the decode-facing registers.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    deliver_pc_d = deliver_pc_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    discard_d    = discard_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_noop_d   = out_noop_q;

    inflight_d = inflight_q + C_CNT_W'(w_grant) - C_CNT_W'(imem.imem_rvalid);
    count_d    = count_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);

    if (w_grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (imem.imem_rvalid && !redirect_valid && (discard_q != '0)) begin
      discard_d = discard_q - C_CNT_W'(1);
    end

    if (w_push) begin
      fifo_d[wr_ptr_q] = imem.imem_rdata;
      wr_ptr_d         = wr_ptr_q + C_PTR_W'(1);
    end

    if (w_pop) begin
      rd_ptr_d     = rd_ptr_q + C_PTR_W'(1);
      out_instr_d  = w_pop_data;
      out_pc_d     = deliver_pc_q;
      out_noop_d   = 1'b0;
      deliver_pc_d = deliver_pc_q + 32'd4;
    end else if (!stall) begin
      out_noop_d = 1'b1;
    end

    // Redirect overrides everything above; every fetch still outstanding is owed a drop.
    if (redirect_valid) begin
      fetch_pc_d   = w_target;
      deliver_pc_d = w_target;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      out_noop_d   = 1'b1;
      discard_d    = inflight_d;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      deliver_pc_q <= RESET_PC;
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      discard_q    <= '0;
      out_instr_q  <= C_NOP;
      out_pc_q     <= RESET_PC;
      out_noop_q   <= 1'b1;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      deliver_pc_q <= deliver_pc_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_noop_q   <= out_noop_d;
    end
  end

  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_noop  = out_noop_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_discarded_q, perf_discarded_d;

  // Event counters; they wrap naturally on overflow.
  always_comb begin
    perf_fetched_d   = perf_fetched_q + 32'(w_pop);
    perf_stall_d     = perf_stall_q + 32'(stall);
    perf_discarded_d = perf_discarded_q + 32'(w_drop);
  end

  // Counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q   <= '0;
      perf_stall_q     <= '0;
      perf_discarded_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_stall_q     <= perf_stall_d;
      perf_discarded_q <= perf_discarded_d;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
  assign perf_discarded    = perf_discarded_q;
`endif

  // Protocol invariants.
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (count_q == C_CNT_W'(BUF_DEPTH))));
  a_no_stray_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem.imem_rvalid && (inflight_q == '0)));
  a_addr_aligned : assert property (@(posedge clk) disable iff (!rst_n)
    (imem.imem_addr[1:0] == 2'b00));

endmodule
`default_nettype wire
